twiddle_mult_stage: RTL and testbench

Parametrised, pipelined complex twiddle multiplier for one radix-2 single-path delay-feedback FFT stage. It takes a streamed complex sample with a valid qualifier and tracks the in-frame sample index with an internal counter. Each sample is multiplied by the stage's twiddle factor W_N^k, which comes from an internal ROM, and the result is presented three cycles later with a matching valid and index. It generalises the fixed 12-bit stage-1 multiplier to any FFT size and width, and adds valid gating, frame resynchronisation and optional rounding.

---
 rtl/twiddle_mult_stage_if.sv | 22 ++
 rtl/twiddle_mult_stage.sv | 81 ++++++++
 tb/tb_twiddle_mult_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/twiddle_mult_stage_if.sv
// twiddle_mult_stage_if: streamed complex sample bus into and out of the twiddle multiplier stage
interface twiddle_mult_stage_if #(
  parameter int DATA_W = 12,
  parameter int IDX_W = 4
);
  logic in_valid;
  logic frame_start;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic out_valid;
  logic signed [DATA_W:0] out_real;
  logic signed [DATA_W:0] out_imag;
  logic [IDX_W-1:0] out_index;
  modport master (
    output in_valid, frame_start, in_real, in_imag,
    input out_valid, out_real, out_imag, out_index
  );
  modport slave (
    input in_valid, frame_start, in_real, in_imag,
    output out_valid, out_real, out_imag, out_index
  );
endinterface

// File: rtl/twiddle_mult_stage.sv
// twiddle_mult_stage: 3-stage complex twiddle multiplier for a radix-2 SDF FFT stage; define TWMUL_ROUND_EN for round-half-up
module twiddle_mult_stage #(
  parameter int DATA_W = 12,
  parameter int TW_W = 12,
  parameter int N_POINT = 16
) (
  input logic clk,
  input logic rst,
  twiddle_mult_stage_if.slave bus
);
  localparam int IDX_W = $clog2(N_POINT);
  localparam int HALF = N_POINT / 2;
  localparam int P_W = DATA_W + TW_W;
  localparam real PI = 3.14159265358979323846;
  localparam real ONE = real'(1 << (TW_W - 2));
  localparam logic signed [TW_W-1:0] W_ONE = TW_W'(1 << (TW_W - 2));
`ifdef TWMUL_ROUND_EN
  localparam int S_W = P_W + 2;
`else
  localparam int S_W = P_W + 1;
`endif
  logic signed [TW_W-1:0] rom_c [HALF];
  logic signed [TW_W-1:0] rom_d [HALF];
  for (genvar g = 0; g < HALF; g++) begin : g_rom
    localparam real ANG = 2.0 * PI * real'(g) / real'(N_POINT);
    localparam real C = ONE * $cos(ANG);
    localparam real S = ONE * $sin(ANG);
    localparam int CI = C >= 0.0 ? $rtoi(C + 0.5) : -$rtoi(0.5 - C);
    localparam int SI = S >= 0.0 ? $rtoi(S + 0.5) : -$rtoi(0.5 - S);
    assign rom_c[g] = TW_W'(CI);
    assign rom_d[g] = TW_W'(-SI);
  end
  logic [IDX_W-1:0] cnt, idx, i1, i2;
  logic v1, v2;
  logic signed [DATA_W-1:0] a1, b1;
  logic signed [TW_W-1:0] c1, d1;
  logic signed [P_W-1:0] ac, bd, ad, bc;
  logic signed [S_W-1:0] re_s, im_s;
  logic unused_bits;
  assign idx = bus.frame_start ? '0 : cnt;
`ifdef TWMUL_ROUND_EN
  localparam logic signed [S_W-1:0] BIAS = S_W'(1) <<< (TW_W - 3);
  assign re_s = S_W'(ac) - S_W'(bd) + BIAS;
  assign im_s = S_W'(ad) + S_W'(bc) + BIAS;
`else
  assign re_s = S_W'(ac) - S_W'(bd);
  assign im_s = S_W'(ad) + S_W'(bc);
`endif
  assign unused_bits = ^{re_s[S_W-1:P_W-1], re_s[TW_W-3:0], im_s[S_W-1:P_W-1], im_s[TW_W-3:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_real <= '0;
      bus.out_imag <= '0;
      bus.out_index <= '0;
    end else begin
      cnt <= bus.in_valid ? idx + 1'b1 : bus.frame_start ? '0 : cnt;
      v1 <= bus.in_valid;
      v2 <= v1;
      bus.out_valid <= v2;
      bus.out_real <= re_s[P_W-2:TW_W-2];
      bus.out_imag <= im_s[P_W-2:TW_W-2];
      bus.out_index <= i2;
    end
  end
  always_ff @(posedge clk) begin
    a1 <= bus.in_real;
    b1 <= bus.in_imag;
    i1 <= idx;
    c1 <= idx[IDX_W-1] ? rom_c[idx[IDX_W-2:0]] : W_ONE;
    d1 <= idx[IDX_W-1] ? rom_d[idx[IDX_W-2:0]] : '0;
    ac <= P_W'(a1) * P_W'(c1);
    bd <= P_W'(b1) * P_W'(d1);
    ad <= P_W'(a1) * P_W'(d1);
    bc <= P_W'(b1) * P_W'(c1);
    i2 <= i1;
  end
endmodule

// File: tb/tb_twiddle_mult_stage.sv
// tb_twiddle_mult_stage: randomized self-checking bench against a floating-point twiddle reference model
module tb_twiddle_mult_stage;
  localparam int DATA_W = 12;
  localparam int TW_W = 12;
  localparam int N_POINT = 16;
  localparam int IDX_W = 4;
  typedef struct {
    logic v;
    logic signed [DATA_W:0] re;
    logic signed [DATA_W:0] im;
    logic [IDX_W-1:0] idx;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  int m_cnt = 0;
  exp_t pipe [3];
  twiddle_mult_stage_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();
  twiddle_mult_stage #(.DATA_W(DATA_W), .TW_W(TW_W), .N_POINT(N_POINT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic void model(input int idx, input int a, input int b, output int re, output int im);
    real ang = 2.0 * 3.141592653589793 * real'(idx - N_POINT / 2) / real'(N_POINT);
    longint one = longint'(1) << (TW_W - 2);
    longint c = idx < N_POINT / 2 ? one : longint'($floor(real'(one) * $cos(ang) + 0.5));
    longint d = idx < N_POINT / 2 ? 0 : -longint'($floor(real'(one) * $sin(ang) + 0.5));
    longint pr = longint'(a) * c - longint'(b) * d;
    longint pq = longint'(a) * d + longint'(b) * c;
`ifdef TWMUL_ROUND_EN
    pr += one / 2;
    pq += one / 2;
`endif
    re = int'(pr >>> (TW_W - 2));
    im = int'(pq >>> (TW_W - 2));
  endfunction
  task automatic tick(input logic r, input logic v, input logic fs, input int a, input int b);
    exp_t e;
    int idx = fs ? 0 : m_cnt;
    int re, im;
    rst = r;
    bus.in_valid = v;
    bus.frame_start = fs;
    bus.in_real = DATA_W'(a);
    bus.in_imag = DATA_W'(b);
    model(idx, a, b, re, im);
    e.v = v && !r;
    e.re = (DATA_W + 1)'(re);
    e.im = (DATA_W + 1)'(im);
    e.idx = IDX_W'(idx);
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e;
    if (r) begin
      foreach (pipe[i]) pipe[i].v = 1'b0;
      m_cnt = 0;
    end else if (v) m_cnt = (idx + 1) % N_POINT;
    else if (fs) m_cnt = 0;
    #1;
  endtask
  function automatic int rnd();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction
  task automatic run_at(input int idx, input int a, input int b);
    tick(0, 1, 1, 0, 0);
    for (int i = 1; i < idx; i++) tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, a, b);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
  endtask
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0, 0, 0);
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_real !== 0 || bus.out_imag !== 0 || bus.out_index !== 0) begin
        fails++;
        $display("FAIL reset_state: got v=%b re=%0d im=%0d idx=%0d, want all 0", bus.out_valid, bus.out_real, bus.out_imag, bus.out_index);
      end
    end
    tick(0, 1, 0, 100, -200);
    for (int j = 1; j <= 3; j++) begin
      tests++;
      if (j < 3 && bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL latency_early: cycle %0d got out_valid=%b, want 0", j, bus.out_valid);
      end
      if (j == 3 && (bus.out_valid !== 1'b1 || bus.out_real !== 100 || bus.out_imag !== -200 || bus.out_index !== 0)) begin
        fails++;
        $display("FAIL latency_out: got v=%b (%0d,%0d) idx=%0d, want v=1 (100,-200) idx=0", bus.out_valid, bus.out_real, bus.out_imag, bus.out_index);
      end
      if (j < 3) tick(0, 0, 0, 0, 0);
    end
  endtask
  task automatic test_bypass();
    int seen = 0;
    for (int k = 1; k <= 11; k++) begin
      if (k <= 8) tick(0, 1, k == 1, k, -k);
      else tick(0, 0, 0, 0, 0);
      tests++;
      if (bus.out_valid !== pipe[2].v || (pipe[2].v && (bus.out_real !== pipe[2].re || bus.out_imag !== pipe[2].im || bus.out_index !== pipe[2].idx))) begin
        fails++;
        $display("FAIL bypass_model: got v=%b (%0d,%0d) idx=%0d, want v=%b (%0d,%0d) idx=%0d", bus.out_valid, bus.out_real, bus.out_imag, bus.out_index, pipe[2].v, pipe[2].re, pipe[2].im, pipe[2].idx);
      end
      if (bus.out_valid === 1'b1) begin
        tests++;
        if (bus.out_real !== seen + 1 || bus.out_imag !== -(seen + 1) || bus.out_index !== IDX_W'(seen)) begin
          fails++;
          $display("FAIL bypass_value: got (%0d,%0d) idx=%0d, want (%0d,%0d) idx=%0d", bus.out_real, bus.out_imag, bus.out_index, seen + 1, -(seen + 1), seen);
        end
        seen++;
      end
    end
    tests++;
    if (seen != 8) begin
      fails++;
      $display("FAIL bypass_count: got %0d outputs, want 8", seen);
    end
  endtask
  task automatic test_minus_j();
    int a_in [2] = '{1024, 0};
    int b_in [2] = '{0, 1024};
    int er [2] = '{0, 1024};
    int ei [2] = '{-1024, 0};
    for (int i = 0; i < 2; i++) begin
      run_at(12, a_in[i], b_in[i]);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_real !== er[i] || bus.out_imag !== ei[i] || bus.out_index !== 12) begin
        fails++;
        $display("FAIL minus_j: got v=%b (%0d,%0d) idx=%0d, want v=1 (%0d,%0d) idx=12", bus.out_valid, bus.out_real, bus.out_imag, bus.out_index, er[i], ei[i]);
      end
    end
  endtask
  task automatic test_quant();
`ifdef TWMUL_ROUND_EN
    int er = 1;
`else
    int er = 0;
`endif
    run_at(10, 1, 0);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_real !== er || bus.out_imag !== -1 || bus.out_index !== 10) begin
      fails++;
      $display("FAIL quant: got v=%b (%0d,%0d) idx=%0d, want v=1 (%0d,-1) idx=10", bus.out_valid, bus.out_real, bus.out_imag, bus.out_index, er);
    end
  endtask
  task automatic test_gaps_wrap();
    int sent = 0, got = 0, tail = 0;
    while (tail < 3) begin
      if (sent < 20 && $urandom_range(0, 2) != 0) begin
        tick(0, 1, sent == 0, rnd(), rnd());
        sent++;
      end else begin
        tick(0, 0, 0, 0, 0);
        if (sent == 20) tail++;
      end
      tests++;
      if (bus.out_valid !== pipe[2].v || (pipe[2].v && (bus.out_real !== pipe[2].re || bus.out_imag !== pipe[2].im || bus.out_index !== pipe[2].idx))) begin
        fails++;
        $display("FAIL gaps_model: got v=%b (%0d,%0d) idx=%0d, want v=%b (%0d,%0d) idx=%0d", bus.out_valid, bus.out_real, bus.out_imag, bus.out_index, pipe[2].v, pipe[2].re, pipe[2].im, pipe[2].idx);
      end
      if (bus.out_valid === 1'b1) begin
        tests++;
        if (bus.out_index !== IDX_W'(got % N_POINT)) begin
          fails++;
          $display("FAIL gaps_index: got idx=%0d, want %0d", bus.out_index, got % N_POINT);
        end
        got++;
      end
    end
    tests++;
    if (got != 20) begin
      fails++;
      $display("FAIL gaps_count: got %0d outputs, want 20", got);
    end
  endtask
  task automatic test_resync();
    for (int c = 0; c < 16; c++) begin
      if (c < 9) tick(0, 1, c == 0 || c == 5, rnd(), rnd());
      else if (c == 9) tick(1, 1, 0, rnd(), rnd());
      else if (c == 13) tick(0, 1, 0, rnd(), rnd());
      else tick(0, 0, 0, 0, 0);
      tests++;
      if (bus.out_valid !== pipe[2].v || (pipe[2].v && (bus.out_real !== pipe[2].re || bus.out_imag !== pipe[2].im || bus.out_index !== pipe[2].idx))) begin
        fails++;
        $display("FAIL resync_model: cycle %0d got v=%b (%0d,%0d) idx=%0d, want v=%b (%0d,%0d) idx=%0d", c, bus.out_valid, bus.out_real, bus.out_imag, bus.out_index, pipe[2].v, pipe[2].re, pipe[2].im, pipe[2].idx);
      end
      if (c == 7 || c == 15) begin
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_index !== 0) begin
          fails++;
          $display("FAIL resync_index: cycle %0d got v=%b idx=%0d, want v=1 idx=0", c, bus.out_valid, bus.out_index);
        end
      end else if (c >= 9) begin
        tests++;
        if (bus.out_valid !== 1'b0) begin
          fails++;
          $display("FAIL resync_drop: cycle %0d got out_valid=%b, want 0", c, bus.out_valid);
        end
      end
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      if (c < 297) tick(0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rnd(), rnd());
      else tick(0, 0, 0, 0, 0);
      tests++;
      if (bus.out_valid !== pipe[2].v || (pipe[2].v && (bus.out_real !== pipe[2].re || bus.out_imag !== pipe[2].im || bus.out_index !== pipe[2].idx))) begin
        fails++;
        $display("FAIL random_model: cycle %0d got v=%b (%0d,%0d) idx=%0d, want v=%b (%0d,%0d) idx=%0d", c, bus.out_valid, bus.out_real, bus.out_imag, bus.out_index, pipe[2].v, pipe[2].re, pipe[2].im, pipe[2].idx);
      end
    end
  endtask
  initial begin
    foreach (pipe[i]) pipe[i].v = 1'b0;
    bus.in_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.in_real = '0;
    bus.in_imag = '0;
    test_reset();
    test_bypass();
    test_minus_j();
    test_quant();
    test_gaps_wrap();
    test_resync();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
